// File: rtl/div_seq_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_addsub_if
// Description : Pipeline handshake and shared add/sub port group of the
//               sequential RV32M divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_addsub_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic            add_sub;
    logic [XLEN-1:0] add_out;

    // Pipeline / adder side
    modport master (
        output start, op, dividend, divisor, add_out,
        input  busy, done, result, add_a, add_b, add_sub
    );

    // Divider side
    modport slave (
        input  start, op, dividend, divisor, add_out,
        output busy, done, result, add_a, add_b, add_sub
    );
endinterface
`default_nettype wire

// File: rtl/div_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_addsub
// Description : Radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU) that
//               borrows the shared EX-stage add/sub block every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_addsub #(
    parameter int XLEN = 32
) (
    input  wire                clk,
    input  wire                rst,
    div_seq_addsub_if.slave    bus
);
    localparam int c_cnt_w = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_dvsr;
    logic [XLEN-1:0]     r_result;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [1:0]          r_op;
    logic                r_neg_a;
    logic                r_neg_b;

    logic                w_in_neg_a;
    logic                w_in_neg_b;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div_zero;
    logic [XLEN-1:0]     w_run_a;
    logic                w_ge;
    logic [XLEN-1:0]     w_sel;
    logic                w_negate;
    logic [XLEN-1:0]     w_add_a;
    logic [XLEN-1:0]     w_add_b;
    logic                w_add_sub;

    // Operand magnitudes are formed in fabric; the shared adder is only used
    // for the iteration subtract and the final sign fix-up.
    assign w_in_neg_a = ~bus.op[0] & bus.dividend[XLEN-1];
    assign w_in_neg_b = ~bus.op[0] & bus.divisor[XLEN-1];
    assign w_abs_a    = w_in_neg_a ? -bus.dividend : bus.dividend;
    assign w_abs_b    = w_in_neg_b ? -bus.divisor  : bus.divisor;
    assign w_div_zero = (bus.divisor == '0);

    // r_rem[XLEN-1] is the bit shifted out of the partial remainder, i.e. its
    // bit XLEN; when set the subtract always fits and the wrapped sum is exact.
    assign w_run_a  = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_ge     = r_rem[XLEN-1] | (w_run_a >= r_dvsr);
    assign w_sel    = r_op[1] ? r_rem   : r_quo;
    assign w_negate = r_op[1] ? r_neg_a : (r_neg_a ^ r_neg_b);

    always_comb begin
        w_state_nxt = r_state;
        w_add_a     = '0;
        w_add_b     = '0;
        w_add_sub   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_add_a   = w_run_a;
                w_add_b   = r_dvsr;
                w_add_sub = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_add_b     = w_sel;
                w_add_sub   = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_neg_a <= w_in_neg_a;
                        r_neg_b <= w_in_neg_b;
                        r_quo   <= w_abs_a;
                        r_rem   <= '0;
                        r_dvsr  <= w_abs_b;
                        r_cnt   <= '0;
                        if (w_div_zero) begin
                            r_result <= bus.op[1] ? bus.dividend : '1;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_ge ? bus.add_out : w_run_a;
                    r_quo <= {r_quo[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_result <= w_negate ? bus.add_out : w_sel;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.result  = r_result;
    assign bus.add_a   = w_add_a;
    assign bus.add_b   = w_add_b;
    assign bus.add_sub = w_add_sub;
endmodule
`default_nettype wire

// File: tb/tb_div_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_addsub
// Description : Directed self-checking bench for div_seq_addsub with a
//               behavioural model of the shared add/sub block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_addsub;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    div_seq_addsub_if #(.XLEN(32)) bus ();

    div_seq_addsub #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.add_out = bus.add_sub ? (bus.add_a - bus.add_b) : (bus.add_a + bus.add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start in cycle 0 (driven before the edge); k counts negedges afterwards,
    // so k equals the cycle number in which the DUT output is sampled.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_k, input int glitch_k);
        int k;
        bit got;
        bit sub_ok;
        bit busy_ok;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        k = 0; got = 1'b0; sub_ok = 1'b1; busy_ok = 1'b1;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (k <= 33 && exp_k == 34 && bus.add_sub !== 1'b1) sub_ok = 1'b0;
            if (bus.done === 1'b1) got = 1'b1;
            bus.start = (k == glitch_k);
            if (k == 1) begin
                bus.dividend = ~a;
                bus.divisor  = b ^ 32'h5;
                bus.op       = ~op;
            end
            if (k == glitch_k) begin
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_done_cycle"}, 32'(k), 32'(exp_k));
        chk({tag, "_result"}, bus.result, exp);
        chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        if (exp_k == 34) chk({tag, "_addsub_run"}, {31'b0, sub_ok}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {30'b0, bus.busy, bus.done}, 32'd0);
        chk({tag, "_held"}, bus.result, exp);
    endtask

    initial begin
        int dones;
        n_tests = 0;
        n_fail  = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {29'b0, bus.busy, bus.done, bus.add_sub}, 32'd0);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_add_ab", bus.add_a | bus.add_b, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7",   2'b01, 32'd100,       32'd7,         32'h0000000E, 34, 0);
        run_op("div_m100_7",   2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2, 34, 0);
        run_op("rem_m100_7",   2'b10, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE, 34, 0);
        run_op("rem_100_m7",   2'b10, 32'd100,       32'hFFFFFFF9,  32'h00000002, 34, 0);
        run_op("remu_bit32",   2'b11, 32'hFFFFFFFF,  32'h80000000,  32'h7FFFFFFF, 34, 0);
        run_op("divu_bit32",   2'b01, 32'hFFFFFFFF,  32'h80000000,  32'h00000001, 34, 0);
        run_op("div_by_zero",  2'b00, 32'h12345678,  32'h0,         32'hFFFFFFFF, 1,  0);
        run_op("rem_by_zero",  2'b10, 32'h12345678,  32'h0,         32'h12345678, 1,  0);
        run_op("divu_by_zero", 2'b01, 32'h00000005,  32'h0,         32'hFFFFFFFF, 1,  0);
        run_op("rem_ovf",      2'b10, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 34, 0);
        run_op("div_7_m100",   2'b00, 32'd7,         32'hFFFFFF9C,  32'h00000000, 34, 0);
        run_op("div_ovf",      2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 34, 0);
        run_op("divu_glitch",  2'b01, 32'd100,       32'd7,         32'h0000000E, 34, 10);
        run_op("div_ovf2",     2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 34, 0);

        // Abort a running divide with reset at cycle 20
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = 2'b01;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_flags", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("rst_abort_result", bus.result, 32'h0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("rst_no_done", 32'(dones), 32'd0);
        run_op("after_rst",    2'b11, 32'd100,       32'd7,         32'h00000002, 34, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/div_seq_addsub.md
Name: div_seq_addsub

Overview:
- Sequential RV32M divider (DIV/DIVU/REM/REMU) for the sail-core EX stage.
- Has no subtractor of its own: drives the shared 32-bit DSP add/sub block through an external port group and consumes its combinational result every cycle, so it is both upstream and downstream of that adder.
- Radix-2 restoring division, one quotient bit per cycle, with a start/busy/done handshake toward the pipeline stall logic.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  32  rs1, captured on accepted start
- divisor  input  32  rs2, captured on accepted start
- busy  output  1  high from the cycle after accepted start through the cycle done is high
- done  output  1  one-cycle pulse; result valid
- result  output  32  quotient or remainder; held until the next accepted start
- add_a  output  32  adder operand 1
- add_b  output  32  adder operand 2
- add_sub  output  1  adder mode: 1 = a-b, 0 = a+b
- add_out  input  32  adder result, combinational from add_a/add_b/add_sub in the same cycle

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; busy=0, done=0, result=0, counter=0; internal registers cleared. Reset mid-operation aborts with no done pulse.
- States and adder drive:
  - IDLE: add_a=0, add_b=0, add_sub=0.
  - RUN: add_a = {rem[30:0], quo[31]}, add_b = dvsr, add_sub=1.
  - FIX: add_a=0, add_b=sel, add_sub=1.
  - DONE: add_a=0, add_b=0, add_sub=0.
- IDLE, start=1 (accept):
  - Signed ops: neg_a = dividend[31], neg_b = divisor[31]. Unsigned ops: both 0.
  - Magnitudes are computed in fabric, not via the adder.
  - quo <= |dividend|, rem <= 0, dvsr <= |divisor|, counter <= 0.
  - divisor==0: go to DONE directly. result = 0xFFFFFFFF for DIV/DIVU; result = raw dividend for REM/REMU.
  - Otherwise go to RUN.
- RUN (exactly 32 cycles):
  - ge = rem[31] | (add_a >= dvsr), an unsigned 32-bit fabric compare. rem[31] acts as bit 32 of the partial remainder.
  - rem <= ge ? add_out : add_a.
  - quo <= {quo[30:0], ge}.
  - counter++; after the 32nd iteration (counter==31) go to FIX.
- FIX (1 cycle):
  - DIV/DIVU: sel = quo, negate = neg_a ^ neg_b.
  - REM/REMU: sel = rem, negate = neg_a.
  - result <= negate ? add_out : sel. Go to DONE.
- DONE (1 cycle): done=1, busy=1; next state IDLE.
- Latency:
  - Normal operation: start high in cycle 0 → RUN in cycles 1–32, FIX in cycle 33, done high in cycle 34.
  - Divide-by-zero: done high in cycle 1.
  - Back-to-back: a new start is accepted in the cycle after done at the earliest.
- Overflow (DIV 0x80000000 / 0xFFFFFFFF) needs no special case: result 0x80000000; REM gives 0.
- start while busy=1 is ignored; operands are not re-captured.
- op, dividend and divisor may change after acceptance without effect.
- done never asserts without a preceding accepted start.

Test Plan:
- DIVU 100 / 7, start in cycle 0 → done only in cycle 34, result 0x0000000E; busy high cycles 1–34; add_sub=1 throughout RUN.
- DIV 0xFFFFFF9C (-100) / 7 → 0xFFFFFFF2 (-14). REM same operands → 0xFFFFFFFE (-2). REM 100 / 0xFFFFFFF9 (-7) → 0x00000002.
- REMU 0xFFFFFFFF / 0x80000000 → 0x7FFFFFFF; DIVU same operands → 0x00000001. Exercises the rem[31] bit-32 path.
- Divisor 0: DIV 0x12345678 → 0xFFFFFFFF; REM 0x12345678 → 0x12345678; done in cycle 1. Overflow DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- start pulsed at cycle 10 of a running DIVU with different operands → ignored; original result returned at cycle 34.
- rst asserted at cycle 20 → busy=0, done=0, result=0 next cycle, no done pulse. A fresh start afterwards completes normally.
